// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default bit timing, counter widths
// and the parity helper, common to transmitter and receiver.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;

  localparam int CLKS_PER_BIT_DEFAULT = 8;
  localparam int BIT_CNT_W = 3;
  localparam int CLK_CNT_W = 4;

  typedef logic [2:0] state_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       busy,
  output logic       done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 16) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT must be in 2..16");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  localparam logic [CLK_CNT_W-1:0] LAST_CLK = CLK_CNT_W'(CLKS_PER_BIT - 1);
  // The stop bit ends one clock early so done lands on the frame's final clock
  // and the next acceptance can follow with no idle gap.
  localparam logic [CLK_CNT_W-1:0] STOP_END = CLK_CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

  state_t                 state;
  logic [CLK_CNT_W-1:0]   clk_count;
  logic [BIT_CNT_W-1:0]   bit_count;
  logic [7:0]             shift_reg;
  logic                   bit_end;
  logic [BIT_CNT_W-1:0]   next_bit;

  assign bit_end  = (clk_count == LAST_CLK);
  assign next_bit = bit_count + BIT_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_count   <= '0;
      shift_reg   <= '0;
      tx_data_out <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_data_out <= 1'b1;
          busy        <= 1'b0;
          if (tx_en && tx_start) begin
            shift_reg   <= tx_data_in;
            bit_count   <= '0;
            clk_count   <= '0;
            busy        <= 1'b1;
            tx_data_out <= 1'b0;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_count   <= '0;
            tx_data_out <= shift_reg[0];
            state       <= DATA;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_count <= '0;
            if (bit_count == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_data_out <= parity_bit(shift_reg, PARITY_ODD[0]);
              state       <= PARITY;
`else
              tx_data_out <= 1'b1;
              state       <= STOP;
`endif
            end else begin
              bit_count   <= next_bit;
              tx_data_out <= shift_reg[next_bit];
            end
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_count   <= '0;
            tx_data_out <= 1'b1;
            state       <= STOP;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (clk_count == STOP_END) begin
            clk_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            clk_count <= clk_count + CLK_CNT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          clk_count   <= '0;
          tx_data_out <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model checked every cycle,
// directed timing pins, and randomized start/enable/reset traffic.
module tb_uart_tx;

  localparam int N = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_data_out;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .tx_data_out(tx_data_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Frame as a bit list: index 0 = start, 1..8 = data LSB first, then parity, then stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: counts clocks since acceptance and reads the line from the bit list.
  bit          active = 1'b0;
  int          age = 0;
  logic [10:0] frame = '1;
  logic        exp_line = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      active   = 1'b0;
      exp_line = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (active) begin
        age++;
        if (age == FL*N - 1) begin
          active   = 1'b0;
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_line = 1'b1;
        end else begin
          exp_line = frame[age / N];
        end
      end else if (tx_en && tx_start) begin
        active   = 1'b1;
        age      = 0;
        frame    = make_frame(tx_data_in);
        exp_line = 1'b0;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("line_busy_done", {29'd0, tx_data_out, busy, done}, {29'd0, exp_line, exp_busy, exp_done});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Send one byte and record mid-bit line samples, busy cycles and the done offset.
  task automatic send_and_sample(input logic [7:0] d, output logic [10:0] mid,
                                 output int busy_cnt, output int done_at);
    mid      = '1;
    busy_cnt = 0;
    done_at  = -1;
    tx_en      = 1'b1;
    tx_data_in = d;
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < FL*N; k++) begin
      if (k % N == N/2) mid[k / N] = tx_data_out;
      busy_cnt += int'(busy);
      if (done) done_at = k;
      step();
    end
  endtask

  logic [10:0] mid;
  int          busy_cnt;
  int          done_at;
  int          done_cnt;

  initial begin
    repeat (3) step();
    check("reset_state", {29'd0, tx_data_out, busy, done}, 32'b100);
    reset = 1'b0;
    step();

`ifdef UART_TX_PARITY_EN
    check("model_frame_a5", {21'd0, make_frame(8'hA5)}, {21'd0, 11'b10101001010});
`else
    check("model_frame_a5", {22'd0, make_frame(8'hA5)[9:0]}, {22'd0, 10'b1101001010});
`endif

    // 0xA5 frame shape and timing
    send_and_sample(8'hA5, mid, busy_cnt, done_at);
`ifdef UART_TX_PARITY_EN
    check("a5_mid_bits", {21'd0, mid}, {21'd0, 11'b10101001010});
    check("a5_done_at", done_at, 87);
    check("a5_busy_cycles", busy_cnt, 87);
    // 0x07 with even parity: three ones, so the parity bit is 1
    send_and_sample(8'h07, mid, busy_cnt, done_at);
    check("p07_parity_bit", {31'd0, mid[9]}, 32'd1);
    check("p07_mid_bits", {21'd0, mid}, {21'd0, 11'b11000001110});
    check("p07_done_at", done_at, 87);
`else
    check("a5_mid_bits", {22'd0, mid[9:0]}, {22'd0, 10'b1101001010});
    check("a5_done_at", done_at, 79);
    check("a5_busy_cycles", busy_cnt, 79);
`endif
    check("a5_idle_line", {31'd0, tx_data_out}, 32'd1);

    // Held tx_start: back-to-back 0x00 then 0xFF with no idle gap
    tx_en = 1'b1; tx_data_in = 8'h00; tx_start = 1'b1;
    step();
    tx_data_in = 8'hFF;
    for (int k = 0; k <= FL*N; k++) begin
      if (k == FL*N - 1) check("b2b_first_done", {30'd0, done, tx_data_out}, 32'b11);
      if (k == FL*N)     check("b2b_second_start", {30'd0, busy, tx_data_out}, 32'b10);
      if (k == FL*N + N/2 + N) check("b2b_ff_bit0", {31'd0, tx_data_out}, 32'd1);
      step();
    end
    repeat (N) step();
    tx_start = 1'b0;
    repeat (FL*N) step();

    // tx_start pulsed mid-frame with another byte is ignored
    tx_data_in = 8'h3C; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (19) step();
    tx_data_in = 8'hC3; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (FL*N) step();
    check("pulse_line_high", {30'd0, tx_data_out, busy}, 32'b10);

    // Reset at cycle 30 of a frame
    tx_data_in = 8'h5A; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (29) step();
    reset = 1'b1;
    step();
    check("midreset_line_busy", {30'd0, tx_data_out, busy}, 32'b10);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < FL*N; k++) begin
      done_cnt += int'(done);
      step();
    end
    check("midreset_no_done", done_cnt, 0);

    // tx_en low blocks acceptance; dropping it mid-frame does not abort
    tx_en = 1'b0; tx_start = 1'b1; tx_data_in = 8'h81;
    repeat (30) step();
    check("en_low_idle", {30'd0, tx_data_out, busy}, 32'b10);
    tx_en = 1'b1; tx_data_in = 8'h96;
    step();
    tx_start = 1'b0;
    repeat (5) step();
    tx_en = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < FL*N; k++) begin
      done_cnt += int'(done);
      step();
    end
    check("en_drop_done_once", done_cnt, 1);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      tx_en      = ($urandom_range(0, 7) != 0);
      tx_start   = ($urandom_range(0, 2) == 0);
      tx_data_in = 8'($urandom);
      step();
    end
    reset = 1'b0; tx_start = 1'b0;
    repeat (FL*N + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
